// File: rtl/pxs_score_keeper.sv
// Pong game-state keeper: counts goals, holds the ball between points, declares a winner.
// Latency: score/serve_dir/winner update one edge after a goal/start rising edge; frame counting lags the end-of-frame pixel by one cycle.
// Backpressure: none; the pixel stream is observed only, and level inputs are edge-detected so a held level counts once.
module pxs_score_keeper #(
  parameter int WIN_SCORE    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int VISIBLECOLS  = 640,
  parameter int VISIBLEROWS  = 480
) (
  input  logic        px_clk,
  input  logic        reset,
  input  logic [25:0] RGBStr_i,
  input  logic        goal_p1,
  input  logic        goal_p2,
  input  logic        start,
  output logic [7:0]  score,
  output logic        serve_hold,
  output logic        serve_dir,
  output logic        game_over,
  output logic [1:0]  winner
);

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  localparam logic [3:0] WIN4   = 4'(WIN_SCORE);
  localparam logic [7:0] RELOAD = 8'(SERVE_FRAMES);

  // Only the pixel coordinates matter; colour and spare bits are ignored.
  logic [9:0] xc;
  logic [9:0] yc;
  logic       unused_bits;
  assign xc          = RGBStr_i[22:13];
  assign yc          = RGBStr_i[12:3];
  assign unused_bits = ^{RGBStr_i[25:23], RGBStr_i[2:0]};

  logic       at_end;
  logic       at_end_q;
  logic       endframe_q;
  logic       goal_p1_q, goal_p2_q, start_q;
  logic       g1_ev, g2_ev, start_ev;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d;
  logic [3:0] p2_q, p2_d;
  logic       dir_q, dir_d;
  logic [1:0] win_q, win_d;
  logic       p1_won, p2_won;

  assign at_end   = (xc == 10'(VISIBLECOLS - 1)) && (yc == 10'(VISIBLEROWS - 1));
  assign g1_ev    = goal_p1 & ~goal_p1_q;
  assign g2_ev    = goal_p2 & ~goal_p2_q;
  assign start_ev = start & ~start_q;

  // Edge-detect history and a one-cycle end-of-frame pulse on the first matching pixel.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      goal_p1_q  <= 1'b0;
      goal_p2_q  <= 1'b0;
      start_q    <= 1'b0;
      at_end_q   <= 1'b0;
      endframe_q <= 1'b0;
    end else begin
      goal_p1_q  <= goal_p1;
      goal_p2_q  <= goal_p2;
      start_q    <= start;
      at_end_q   <= at_end;
      endframe_q <= at_end & ~at_end_q;
    end
  end

  // Game state registers.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      state_q <= ST_HOLD;
      cnt_q   <= RELOAD;
      p1_q    <= 4'd0;
      p2_q    <= 4'd0;
      dir_q   <= 1'b0;
      win_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
    end
  end

  // Next-state logic: restart beats goals; goals only count in PLAY; digits saturate at WIN_SCORE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    dir_d   = dir_q;
    win_d   = win_q;
    p1_won  = 1'b0;
    p2_won  = 1'b0;
    if (start_ev) begin
      state_d = ST_HOLD;
      cnt_d   = RELOAD;
      p1_d    = 4'd0;
      p2_d    = 4'd0;
      win_d   = 2'b00;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (endframe_q) begin
            if (cnt_q <= 8'd1) begin
              state_d = ST_PLAY;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        ST_PLAY: begin
          if (g1_ev || g2_ev) begin
            if (g1_ev && (p1_q != WIN4)) p1_d = p1_q + 4'd1;
            if (g2_ev && (p2_q != WIN4)) p2_d = p2_q + 4'd1;
            // The scorer's opponent receives the next serve; a double goal leaves it alone.
            if (g1_ev && !g2_ev) dir_d = 1'b1;
            if (g2_ev && !g1_ev) dir_d = 1'b0;
            p1_won = g1_ev && (p1_d == WIN4);
            p2_won = g2_ev && (p2_d == WIN4);
            if (p1_won || p2_won) begin
              state_d = ST_OVER;
              win_d   = {p2_won, p1_won};
            end else begin
              state_d = ST_HOLD;
              cnt_d   = RELOAD;
            end
          end
        end
        ST_OVER: begin
          state_d = ST_OVER;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = RELOAD;
        end
      endcase
    end
  end

  assign score      = {p2_q, p1_q};
  assign serve_hold = (state_q != ST_PLAY);
  assign serve_dir  = dir_q;
  assign game_over  = (state_q == ST_OVER);
  assign winner     = win_q;

endmodule
